// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one shared full-adder slice (two half adders
// plus a carry OR) walks WIDTH operand bits LSB first, one bit per clock.

// Single half-adder stage; instanced twice to form the full-adder slice.
module serial_adder_ha (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   sa, sb;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               s1, c1, s2, c2, cnext;

  // Shared slice: stage 1 adds the operand bits, stage 2 folds in the carry.
  serial_adder_ha u_ha1 (.x(sa[0]), .y(sb[0]), .s(s1), .c(c1));
  serial_adder_ha u_ha2 (.x(s1),    .y(carry), .s(s2), .c(c2));
  assign cnext = c1 | c2;

  // Sequencer: operand capture, bit shifting, carry/count and handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      sa    <= '0;
      sb    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            carry <= cin;
            sum   <= '0;
            cout  <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sum   <= {s2, sum[WIDTH-1:1]};
          sa    <= {1'b0, sa[WIDTH-1:1]};
          sb    <= {1'b0, sb[WIDTH-1:1]};
          carry <= cnext;
          cnt   <= cnt + CNT_W'(1);
          // Last bit goes in on this edge; the final carry becomes cout.
          if (cnt == CNT_W'(WIDTH - 1)) begin
            cout  <= cnext;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: vector table, multi-cycle corner
// sequences and a wide operand sweep against a + b + cin.
module tb_serial_adder_ctrl;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0, b = '0;
  logic             cin = 1'b0;
  logic             busy, done, cout;
  logic [WIDTH-1:0] sum;

  int n_vec = 0;
  int n_miss = 0;
  int done_cnt = 0;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
  } vec_t;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  // Every-cycle watch: busy/done exclusion and done pulse counting.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (busy && done) begin
      n_miss++;
      $display("FAIL busy_done_excl: busy=%0b done=%0b required not both", busy, done);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Wait for done with a budget; returns cycles counted since the call.
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done && lat < 30);
  endtask

  // One complete operation from accept edge to return to IDLE.
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                        input logic tc, input logic [WIDTH-1:0] es, input logic ec,
                        input string nm);
    int lat;
    @(negedge clk);
    a = ta; b = tb_; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, " busy_at_accept"}, {31'd0, busy}, 32'd1);
    chk({nm, " sum_cleared"}, {24'd0, sum}, 32'd0);
    wait_done(lat);
    chk({nm, " latency"}, lat, WIDTH);
    chk({nm, " sum"}, {24'd0, sum}, {24'd0, es});
    chk({nm, " cout"}, {31'd0, cout}, {31'd0, ec});
    @(posedge clk); #1;
    chk({nm, " done_one_cycle"}, {31'd0, done}, 32'd0);
    chk({nm, " sum_held"}, {23'd0, cout, sum}, {23'd0, ec, es});
  endtask

  initial begin
    vec_t vecs[8];
    int   lat, d0;
    logic [WIDTH:0] full;
    logic [WIDTH-1:0] ha[3], hb[3];

    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[5] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b1};
    vecs[6] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0};
    vecs[7] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0};

    // Reset state
    #12;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset sum", {24'd0, sum}, 32'd0);
    chk("reset cout", {31'd0, cout}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout,
             $sformatf("vec%0d", i));

    // Start pulsed 3 cycles into RUN is ignored and not queued
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    d0 = done_cnt;
    repeat (2) @(posedge clk);
    @(negedge clk); a = 8'h11; b = 8'h22; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(lat);
    chk("ignore sum", {24'd0, sum}, 32'h46);
    chk("ignore cout", {31'd0, cout}, 32'd0);
    repeat (6) @(posedge clk); #1;
    chk("ignore busy_after", {31'd0, busy}, 32'd0);
    chk("ignore one_done", done_cnt - d0, 32'd1);

    // Asynchronous reset 4 cycles into RUN
    @(negedge clk);
    a = 8'hF0; b = 8'h0F; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b0; #1;
    chk("midreset busy", {31'd0, busy}, 32'd0);
    chk("midreset sum", {24'd0, sum}, 32'd0);
    chk("midreset cout", {31'd0, cout}, 32'd0);
    repeat (12) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("midreset no_done", done_cnt - d0, 32'd0);
    run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "after_reset");

    // start held high: accepts every WIDTH+2 cycles, each with its own operands
    ha[0] = 8'h10; hb[0] = 8'h20;
    ha[1] = 8'hC8; hb[1] = 8'h64;
    ha[2] = 8'h7F; hb[2] = 8'h01;
    @(negedge clk);
    a = ha[0]; b = hb[0]; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      full = {1'b0, ha[k]} + {1'b0, hb[k]};
      if (k < 2) begin a = ha[k+1]; b = hb[k+1]; end
      wait_done(lat);
      chk($sformatf("held%0d latency", k), lat, WIDTH);
      chk($sformatf("held%0d result", k), {23'd0, cout, sum}, {23'd0, full});
      @(posedge clk); #1;
      chk($sformatf("held%0d stable", k), {23'd0, cout, sum}, {23'd0, full});
      @(posedge clk); #1;
      chk($sformatf("held%0d reaccept", k), {31'd0, busy}, 32'd1);
    end
    @(negedge clk); start = 1'b0;
    wait_done(lat);
    repeat (2) @(posedge clk);

    // Operand sweep
    for (int i = 0; i < 1000; i++) begin
      logic [WIDTH-1:0] ra, rb;
      logic             rc;
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
      full = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
      run_op(ra, rb, rc, full[WIDTH-1:0], full[WIDTH], $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial addition sequencer. It adds two WIDTH-bit operands one bit per clock through a single shared 1-bit full-adder slice, which is built from two half-adder stages plus a carry OR. It owns the operand shift registers, the carry flop, the bit counter and the start/busy/done handshake. It lets an area-constrained datapath reuse one half-adder pair instead of a WIDTH-bit ripple adder.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32
CNT_W, $clog2(WIDTH)+1, bit-counter width; derived, do not override

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request to begin an addition; sampled only in IDLE
a  input  WIDTH  operand A; captured on accepted start
b  input  WIDTH  operand B; captured on accepted start
cin  input  1  carry-in; captured on accepted start
busy  output  1  high while bits are being processed (RUN)
done  output  1  one-cycle pulse; result valid from this cycle on
sum  output  WIDTH  result; held stable until the next accepted start
cout  output  1  final carry-out; held with sum

Behaviour:
- Decided: one clock, clk; reset rst_n is asynchronous, active-low. All flops clear immediately on rst_n=0, independent of clk.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, internal shift registers=0, carry=0, counter=0.
- FSM states:
  - IDLE: waiting for start.
  - RUN: processing bits.
  - DONE: single cycle, then back to IDLE.
- IDLE -> RUN, at the edge E0 where start=1:
  - sa<=a, sb<=b, carry<=cin, sum<=0, cout<=0, cnt<=0, busy<=1.
- RUN, each edge:
  - Half-adder stage 1: s1=sa[0]^sb[0], c1=sa[0]&sb[0].
  - Half-adder stage 2: s2=s1^carry, c2=s1&carry.
  - Register updates: sum<={s2, sum[WIDTH-1:1]}; sa,sb shift right with 0 fill; carry<=c1|c2; cnt<=cnt+1.
- RUN -> DONE, at the edge where cnt==WIDTH-1 (edge E(WIDTH)):
  - The last bit is shifted in on that edge.
  - cout<=c1|c2, busy<=0, done<=1.
- DONE -> IDLE on the next edge; done<=0.
- Latency: bit i (LSB first) is processed at edge E(i+1). done is high for exactly one cycle, between E(WIDTH) and E(WIDTH+1). Minimum start-to-start spacing is WIDTH+2 cycles.
- start while in RUN or DONE: ignored, not queued. Operand changes on a/b/cin outside the accepting edge have no effect.
- sum and cout are not updated outside RUN/DONE. After done they hold until the next accepted start clears them.
- Arithmetic: {cout,sum} == a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
- Reset mid-RUN: the operation is abandoned, all outputs return to reset values, and no done pulse is issued. The first start after rst_n deasserts is accepted normally.
- busy and done are never high in the same cycle.

Test Plan:
- WIDTH=8; a=0x00, b=0x00, cin=0 -> busy high for 8 cycles; done pulses 8 cycles after start edge; sum=0x00, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1. Then a=0x3C, b=0x0F, cin=0 -> sum=0x4B, cout=0.
- start pulsed again 3 cycles into RUN with a=0x11, b=0x22 -> ignored; result is still for the original operands; exactly one done pulse.
- rst_n driven low 4 cycles into RUN -> busy=0, sum=0, cout=0 immediately, no done. After release, a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1.
- start held high continuously with new operands applied each op -> ops accepted every WIDTH+2=10 cycles. Each done matches its own operands, and sum is stable between dones.
- Random sweep of 1000 a/b/cin triples -> every {cout,sum} equals a+b+cin; busy/done mutual exclusion holds every cycle.
